// File: rtl/ysyx_22041461_scoreboard.sv
// Register-hazard and CSR-serialisation scoreboard for the 5-stage core.
// Counts in-flight writes per GPR between ID issue and WB retire/kill, and stalls ID as needed.
module ysyx_22041461_scoreboard #(
    parameter int CNT_W = 2,
    parameter int TOT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic             id_rs1_ren,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs2_ren,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_wen,
    input  logic             id_serial,
    output logic             id_stall,
    output logic             id_issue,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             wb_rd_wen,
    input  logic             wb_serial,
    input  logic             kill_valid,
    input  logic [4:0]       kill_rd,
    input  logic             kill_rd_wen,
    input  logic             kill_serial,
    output logic [TOT_W-1:0] busy_cnt,
    output logic             serial_busy,
    output logic             err
);

    typedef enum logic {
        RUN    = 1'b0,
        SERIAL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;
    localparam int CW = CNT_W + 2;
    localparam int TW = TOT_W + 2;

    state_t                  state;
    logic [31:0][CNT_W-1:0]  pend_cnt;
    logic [31:0][CNT_W-1:0]  cnt_nxt;
    logic [31:0]             cnt_under;

    logic                    rs1_pend;
    logic                    rs2_pend;
    logic                    rd_full;
    logic                    wb_ser_hit;
    logic                    kill_ser_hit;
    logic [TW-1:0]           busy_sum;
    logic [TW-1:0]           busy_dn;
    logic                    busy_under;
    logic [TOT_W-1:0]        busy_nxt;
    logic                    same_rd_err;
    logic                    serial_err;
    logic                    viol;

    // Issue handshake: id_valid is the request, ~id_stall the grant; id_issue is
    // their AND and the instruction is accepted on the edge where it is high.
    // The grant depends only on registered state, never on same-cycle WB traffic.
    assign rs1_pend = id_rs1_ren & (pend_cnt[id_rs1] != '0);
    assign rs2_pend = id_rs2_ren & (pend_cnt[id_rs2] != '0);
    assign rd_full  = id_rd_wen & (pend_cnt[id_rd] == CNT_MAX);

    assign id_stall = id_valid & (rs1_pend | rs2_pend | (state == SERIAL) |
                                  (id_serial & (busy_cnt != '0)) | rd_full |
                                  (busy_cnt == TOT_MAX));
    assign id_issue = id_valid & ~id_stall;

    assign wb_ser_hit   = wb_valid & wb_serial;
    assign kill_ser_hit = kill_valid & kill_serial;
    assign serial_busy  = (state == SERIAL);

    // x0 is never tracked: its slot is tied to zero and cannot underflow.
    assign cnt_nxt[0]   = '0;
    assign cnt_under[0] = 1'b0;

    for (genvar r = 1; r < 32; r++) begin : g_cnt
        logic          up;
        logic          wb_hit;
        logic          kill_hit;
        logic [CW-1:0] sum_v;
        logic [CW-1:0] dn_v;

        assign up       = id_issue & id_rd_wen & (id_rd == 5'(r));
        assign wb_hit   = wb_valid & wb_rd_wen & (wb_rd == 5'(r));
        assign kill_hit = kill_valid & kill_rd_wen & (kill_rd == 5'(r));
        assign sum_v    = CW'(pend_cnt[r]) + CW'(up);
        assign dn_v     = CW'(wb_hit) + CW'(kill_hit);
        // Net update; a decrement below zero saturates and is flagged.
        assign cnt_under[r] = (sum_v < dn_v);
        assign cnt_nxt[r]   = cnt_under[r] ? '0 : CNT_W'(sum_v - dn_v);
    end

    assign busy_sum   = TW'(busy_cnt) + TW'(id_issue);
    assign busy_dn    = TW'(wb_valid) + TW'(kill_valid);
    assign busy_under = (busy_sum < busy_dn);
    assign busy_nxt   = busy_under ? '0 : TOT_W'(busy_sum - busy_dn);

    assign same_rd_err = wb_valid & kill_valid & wb_rd_wen & kill_rd_wen &
                         (wb_rd == kill_rd) & (wb_rd != 5'd0) &
                         (pend_cnt[wb_rd] == CNT_W'(1));

    // In RUN nothing serialising is in flight; in SERIAL exactly one is, so it
    // cannot both retire and be killed.
    assign serial_err = (state == RUN) ? (wb_ser_hit | kill_ser_hit)
                                       : (wb_ser_hit & kill_ser_hit);

    assign viol = (|cnt_under) | busy_under | same_rd_err | serial_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (id_issue & id_serial) state <= SERIAL;
                SERIAL:  if (wb_ser_hit | kill_ser_hit) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_cnt <= '0;
            busy_cnt <= '0;
            err      <= 1'b0;
        end else begin
            pend_cnt <= cnt_nxt;
            busy_cnt <= busy_nxt;
            err      <= err | viol;
        end
    end

endmodule

// File: tb/tb_ysyx_22041461_scoreboard.sv
// Bench for ysyx_22041461_scoreboard: directed scenarios plus randomized traffic
// checked against an in-flight list and per-register counts kept as plain integers.
module tb_ysyx_22041461_scoreboard;

    localparam int CNT_W = 2;
    localparam int TOT_W = 3;
    localparam int CMAX  = 3;
    localparam int BMAX  = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs1 = '0;
    logic             id_rs1_ren = 1'b0;
    logic [4:0]       id_rs2 = '0;
    logic             id_rs2_ren = 1'b0;
    logic [4:0]       id_rd = '0;
    logic             id_rd_wen = 1'b0;
    logic             id_serial = 1'b0;
    logic             id_stall;
    logic             id_issue;
    logic             wb_valid = 1'b0;
    logic [4:0]       wb_rd = '0;
    logic             wb_rd_wen = 1'b0;
    logic             wb_serial = 1'b0;
    logic             kill_valid = 1'b0;
    logic [4:0]       kill_rd = '0;
    logic             kill_rd_wen = 1'b0;
    logic             kill_serial = 1'b0;
    logic [TOT_W-1:0] busy_cnt;
    logic             serial_busy;
    logic             err;

    ysyx_22041461_scoreboard #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_ren(id_rs1_ren),
        .id_rs2(id_rs2), .id_rs2_ren(id_rs2_ren), .id_rd(id_rd),
        .id_rd_wen(id_rd_wen), .id_serial(id_serial),
        .id_stall(id_stall), .id_issue(id_issue),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_wen(wb_rd_wen), .wb_serial(wb_serial),
        .kill_valid(kill_valid), .kill_rd(kill_rd), .kill_rd_wen(kill_rd_wen),
        .kill_serial(kill_serial),
        .busy_cnt(busy_cnt), .serial_busy(serial_busy), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding writes per register, in-flight list, mode, error.
    int          cnt_m[32];
    int          busy_m;
    bit          ser_m;
    bit          err_m;
    logic [6:0]  exp_q[$];     // {serial, wen, rd} of every issued, unretired instruction
    int          vectors = 0;
    int          miscompares = 0;

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        busy_m = 0;
        ser_m  = 1'b0;
        err_m  = 1'b0;
        exp_q.delete();
    endfunction

    function automatic bit model_stall();
        bit hz;
        hz = (id_rs1_ren && id_rs1 != 0 && cnt_m[id_rs1] != 0) ||
             (id_rs2_ren && id_rs2 != 0 && cnt_m[id_rs2] != 0);
        return id_valid && (hz || ser_m || (id_serial && busy_m != 0) ||
                            (id_rd_wen && id_rd != 0 && cnt_m[id_rd] == CMAX) ||
                            busy_m == BMAX);
    endfunction

    // Advance one clock and apply the same cycle's events to the model.
    task automatic tick();
        bit iss;
        bit wb_s;
        bit kl_s;
        int nv;
        @(posedge clk);
        iss  = id_valid && !model_stall();
        wb_s = wb_valid && wb_serial;
        kl_s = kill_valid && kill_serial;
        if (wb_valid && kill_valid && wb_rd_wen && kill_rd_wen && wb_rd == kill_rd &&
            wb_rd != 0 && cnt_m[wb_rd] == 1) err_m = 1'b1;
        if (!ser_m && (wb_s || kl_s)) err_m = 1'b1;
        if (ser_m && wb_s && kl_s) err_m = 1'b1;
        for (int r = 1; r < 32; r++) begin
            nv = cnt_m[r];
            if (iss && id_rd_wen && id_rd == r) nv = nv + 1;
            if (wb_valid && wb_rd_wen && wb_rd == r) nv = nv - 1;
            if (kill_valid && kill_rd_wen && kill_rd == r) nv = nv - 1;
            if (nv < 0) begin err_m = 1'b1; nv = 0; end
            cnt_m[r] = nv;
        end
        nv = busy_m + (iss ? 1 : 0) - (wb_valid ? 1 : 0) - (kill_valid ? 1 : 0);
        if (nv < 0) begin err_m = 1'b1; nv = 0; end
        busy_m = nv;
        if (!ser_m) ser_m = iss && id_serial;
        else if (wb_s || kl_s) ser_m = 1'b0;
        if (iss) exp_q.push_back({id_serial, id_rd_wen, id_rd});
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic r1en,
                            input logic [4:0] rs2, input logic r2en,
                            input logic [4:0] rd, input logic wen, input logic ser);
        id_valid = v; id_rs1 = rs1; id_rs1_ren = r1en; id_rs2 = rs2; id_rs2_ren = r2en;
        id_rd = rd; id_rd_wen = wen; id_serial = ser;
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] rd, input logic wen, input logic ser);
        wb_valid = v; wb_rd = rd; wb_rd_wen = wen; wb_serial = ser;
    endtask

    task automatic drive_kill(input logic v, input logic [4:0] rd, input logic wen, input logic ser);
        kill_valid = v; kill_rd = rd; kill_rd_wen = wen; kill_serial = ser;
    endtask

    task automatic set_idle();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        drive_wb(0, 0, 0, 0);
        drive_kill(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        model_clear();
        drive_id(1, 5, 1, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", id_stall); end
        vectors++; if (busy_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_busy: got %0d want 0", busy_cnt); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        vectors++; if (serial_busy !== 1'b0) begin miscompares++; $display("FAIL reset_serial: got %b want 0", serial_busy); end
        do_reset();
    endtask

    task automatic test_raw_hazard();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 5, 1, 0);
        @(negedge clk);
        vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL raw_first: got %b want 0", id_stall); end
        tick();
        drive_id(1, 5, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL raw_stall: got %b want 1", id_stall); end
        tick();
        drive_wb(1, 5, 1, 0);
        @(negedge clk);
        vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL raw_no_bypass: got %b want 1", id_stall); end
        tick();
        drive_wb(0, 0, 0, 0);
        @(negedge clk);
        vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL raw_release: got %b want 0", id_stall); end
        vectors++; if (busy_cnt !== 3'd0) begin miscompares++; $display("FAIL raw_busy: got %0d want 0", busy_cnt); end
        tick();
        set_idle();
        @(negedge clk);
        vectors++; if (busy_cnt !== 3'd1) begin miscompares++; $display("FAIL raw_busy_after: got %0d want 1", busy_cnt); end
    endtask

    task automatic test_x0();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drive_id(1, 0, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL x0_stall: got %b want 0", id_stall); end
        vectors++; if (busy_cnt !== 3'd1) begin miscompares++; $display("FAIL x0_busy1: got %0d want 1", busy_cnt); end
        tick();
        set_idle();
        drive_wb(1, 0, 1, 0);
        tick();
        @(negedge clk);
        vectors++; if (busy_cnt !== 3'd1) begin miscompares++; $display("FAIL x0_retire: got %0d want 1", busy_cnt); end
        tick();
        drive_wb(0, 0, 0, 0);
        @(negedge clk);
        vectors++; if (busy_cnt !== 3'd0) begin miscompares++; $display("FAIL x0_busy0: got %0d want 0", busy_cnt); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL x0_err: got %b want 0", err); end
    endtask

    task automatic test_counter_sat();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 7, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL sat_issue%0d: got %b want 0", i, id_stall); end
            tick();
        end
        @(negedge clk);
        vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL sat_full: got %b want 1", id_stall); end
        drive_id(0, 0, 0, 0, 0, 7, 1, 0);
        drive_wb(1, 7, 1, 0);
        tick();
        drive_id(1, 0, 0, 0, 0, 7, 1, 0);
        @(negedge clk);
        vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL sat_same_cycle: got %b want 0", id_stall); end
        tick();
        drive_wb(0, 0, 0, 0);
        @(negedge clk);
        vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL sat_held_two: got %b want 0", id_stall); end
        vectors++; if (busy_cnt !== 3'd2) begin miscompares++; $display("FAIL sat_busy2: got %0d want 2", busy_cnt); end
        tick();
        @(negedge clk);
        vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL sat_full_again: got %b want 1", id_stall); end
        vectors++; if (busy_cnt !== 3'd3) begin miscompares++; $display("FAIL sat_busy3: got %0d want 3", busy_cnt); end
        set_idle();
        drive_wb(1, 7, 1, 0);
        for (int i = 0; i < 3; i++) tick();
        drive_wb(0, 0, 0, 0);
        @(negedge clk);
        vectors++; if (busy_cnt !== 3'd0) begin miscompares++; $display("FAIL sat_drain: got %0d want 0", busy_cnt); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL sat_err: got %b want 0", err); end
    endtask

    task automatic test_serial();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 1, 1, 0);
        tick();
        drive_id(1, 0, 0, 0, 0, 2, 1, 0);
        tick();
        drive_id(1, 0, 0, 0, 0, 3, 1, 1);
        @(negedge clk);
        vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL ser_wait2: got %b want 1", id_stall); end
        tick();
        drive_wb(1, 1, 1, 0);
        @(negedge clk);
        vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL ser_wait_retire: got %b want 1", id_stall); end
        tick();
        drive_wb(1, 2, 1, 0);
        @(negedge clk);
        vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL ser_wait1: got %b want 1", id_stall); end
        tick();
        drive_wb(0, 0, 0, 0);
        @(negedge clk);
        vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL ser_go: got %b want 0", id_stall); end
        tick();
        drive_id(1, 0, 0, 0, 0, 4, 1, 0);
        @(negedge clk);
        vectors++; if (serial_busy !== 1'b1) begin miscompares++; $display("FAIL ser_busy: got %b want 1", serial_busy); end
        vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL ser_block: got %b want 1", id_stall); end
        tick();
        drive_wb(1, 3, 1, 1);
        @(negedge clk);
        vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL ser_block_retire: got %b want 1", id_stall); end
        tick();
        drive_wb(0, 0, 0, 0);
        @(negedge clk);
        vectors++; if (serial_busy !== 1'b0) begin miscompares++; $display("FAIL ser_run: got %b want 0", serial_busy); end
        vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL ser_unblock: got %b want 0", id_stall); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ser_err: got %b want 0", err); end
    endtask

    task automatic test_kill_err();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 9, 1, 0);
        tick();
        set_idle();
        drive_kill(1, 9, 1, 0);
        tick();
        drive_kill(0, 0, 0, 0);
        @(negedge clk);
        vectors++; if (busy_cnt !== 3'd0) begin miscompares++; $display("FAIL kill_busy: got %0d want 0", busy_cnt); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL kill_ok: got %b want 0", err); end
        drive_kill(1, 9, 1, 0);
        tick();
        drive_kill(0, 0, 0, 0);
        @(negedge clk);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL kill_twice: got %b want 1", err); end
        tick();
        tick();
        @(negedge clk);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", err); end
        rst = 1'b0;
        model_clear();
        #1;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_async_clear: got %b want 0", err); end
        @(posedge clk);
        #1 rst = 1'b1;
        drive_wb(1, 0, 0, 0);
        tick();
        drive_wb(0, 0, 0, 0);
        @(negedge clk);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL first_cycle_retire: got %b want 1", err); end
    endtask

    task automatic test_random();
        logic [6:0] e;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            set_idle();
            drive_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 7) == 0);
            if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                e = exp_q.pop_front();
                drive_wb(1, e[4:0], e[5], e[6]);
            end
            if (exp_q.size() > 0 && $urandom_range(0, 5) == 0) begin
                e = exp_q.pop_back();
                drive_kill(1, e[4:0], e[5], e[6]);
            end
            if (c >= 700 && $urandom_range(0, 19) == 0)
                drive_kill(1, 5'($urandom_range(0, 31)), 1'b1, 1'($urandom_range(0, 1)));
            @(negedge clk);
            vectors++; if (id_stall !== model_stall()) begin miscompares++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, id_stall, model_stall()); end
            vectors++; if (id_issue !== (id_valid && !model_stall())) begin miscompares++; $display("FAIL rnd_issue c=%0d: got %b want %b", c, id_issue, id_valid && !model_stall()); end
            vectors++; if (busy_cnt !== TOT_W'(busy_m)) begin miscompares++; $display("FAIL rnd_busy c=%0d: got %0d want %0d", c, busy_cnt, busy_m); end
            vectors++; if (serial_busy !== ser_m) begin miscompares++; $display("FAIL rnd_serial c=%0d: got %b want %b", c, serial_busy, ser_m); end
            vectors++; if (err !== err_m) begin miscompares++; $display("FAIL rnd_err c=%0d: got %b want %b", c, err, err_m); end
            tick();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_raw_hazard();
        test_x0();
        test_counter_sat();
        test_serial();
        test_kill_err();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
